// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_BITS data bits (MSB first) plus one parity bit per frame,
// checked with a running XOR. Reports word, parity error and a saturating error count.
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  input  logic                 err_clr,
  output logic                 frame_done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(DATA_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_PARITY  = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   acc, acc_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt, sh_in;
  logic [ERR_CNT_W-1:0]   ecnt_nxt;
  logic                   accept, err, to_report;

  assign in_ready = !rst && (state != S_REPORT);
  assign accept   = in_valid && in_ready;
  assign err      = acc ^ in_bit ^ ODD;

  // First bit received ends up in the MSB after DATA_BITS shifts.
  if (DATA_BITS == 1) begin : g_one
    assign sh_in = in_bit;
  end else begin : g_many
    assign sh_in = {shreg[DATA_BITS-2:0], in_bit};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    shreg_nxt = shreg;
    to_report = 1'b0;
    case (state)
      S_COLLECT: begin
        if (accept) begin
          shreg_nxt = sh_in;
          acc_nxt   = acc ^ in_bit;
          if (cnt == LAST) state_nxt = S_PARITY;
          else             cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (accept) begin
          state_nxt = S_REPORT;
          to_report = 1'b1;
        end
      end
      S_REPORT: begin
        state_nxt = S_COLLECT;
        cnt_nxt   = '0;
        acc_nxt   = 1'b0;
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  // Clear wins first, then a failing frame on the same edge still counts.
  always_comb begin
    ecnt_nxt = err_clr ? '0 : err_count;
    if (to_report && err && (ecnt_nxt != ERR_MAX)) ecnt_nxt = ecnt_nxt + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_COLLECT;
      cnt        <= '0;
      acc        <= 1'b0;
      shreg      <= '0;
      frame_done <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      shreg      <= shreg_nxt;
      frame_done <= to_report;
      err_count  <= ecnt_nxt;
      if (to_report) begin
        data_out   <= shreg;
        parity_err <= err;
      end
    end
  end

endmodule
